ll_step_engine: RTL and testbench

- Parametrised successor to the lander datapath/control pair: one block holds the lander state and advances it one physics step per `tick`.
- Arithmetic is digit-serial BCD, one digit per clock, so any digit count uses four single-digit adder slices.
- Includes landing/crash detection, fuel-limited thrust and tick-overrun reporting.
- Sits between the clock prescaler/keysync (source of `tick`, `thrust_wr`) and the display block.

---
 rtl/ll_step_engine_if.sv | 30 +++
 rtl/ll_step_engine.sv | 179 +++++++++++++++++
 tb/tb_ll_step_engine.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ll_step_engine_if.sv
// Handshake and status bundle between the lander step engine and its neighbours.
// The master drives tick/thrust writes; the slave (engine) returns lander state.
interface ll_step_engine_if #(
  parameter int DIGITS = 4
);
  localparam int W = 4 * DIGITS;

  logic         tick;
  logic         thrust_wr;
  logic [3:0]   thrust_in;
  logic [W-1:0] alt;
  logic [W-1:0] vel;
  logic [W-1:0] fuel;
  logic [3:0]   thrust;
  logic         busy;
  logic         step_done;
  logic         overrun;
  logic         land;
  logic         crash;

  modport master (
    output tick, thrust_wr, thrust_in,
    input  alt, vel, fuel, thrust, busy, step_done, overrun, land, crash
  );

  modport slave (
    input  tick, thrust_wr, thrust_in,
    output alt, vel, fuel, thrust, busy, step_done, overrun, land, crash
  );
endinterface

// File: rtl/ll_step_engine.sv
// Lunar lander step engine: digit-serial BCD physics update, one digit per clock,
// with landing/crash detection, fuel-limited thrust and tick-overrun reporting.
module ll_step_engine #(
  parameter int                  DIGITS   = 4,
  parameter logic [4*DIGITS-1:0] ALTITUDE = 'h4500,
  parameter logic [4*DIGITS-1:0] VELOCITY = 'h0,
  parameter logic [4*DIGITS-1:0] FUEL     = 'h800,
  parameter logic [3:0]          THRUST   = 4'h5,
  parameter logic [4*DIGITS-1:0] GRAVITY  = 'h5,
  parameter logic [4*DIGITS-1:0] SAFE_VEL = 'h9970
) (
  input  logic             clk,
  input  logic             rst,   // active-low, asynchronous
  ll_step_engine_if.slave  bus
);
  // Results are assembled by shifting digits in from the top, so DIGITS >= 2.
  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {IDLE, CALC, CHECK, LANDED, CRASHED} state_t;

  function automatic logic [4:0] bcd_add(input logic [3:0] a, input logic [3:0] b,
                                         input logic cin);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
    else          return {1'b0, s[3:0]};
  endfunction

  // Bit 4 of the raw difference flags a borrow; adding ten restores the digit.
  function automatic logic [4:0] bcd_sub(input logic [3:0] a, input logic [3:0] b,
                                         input logic bin);
    logic [4:0] s;
    s = {1'b0, a} - {1'b0, b} - {4'b0, bin};
    if (s[4]) return {1'b1, 4'(s + 5'd10)};
    else      return {1'b0, s[3:0]};
  endfunction

  function automatic logic is_neg(input logic [W-1:0] x);
    return x[W-1 -: 4] >= 4'd5;
  endfunction

  function automatic logic non_pos(input logic [W-1:0] x);
    return is_neg(x) || (x == '0);
  endfunction

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  alt_r, vel_r, fuel_r;
  logic [3:0]    thrust_r;
  logic          busy_r, step_done_r, overrun_r, land_r, crash_r;

  // Operand shift registers (LSD in [3:0]) and the unshifted velocity for CHECK.
  logic [W-1:0]  a_sh, v_sh, f_sh, g_sh, te_sh, v_op;
  logic [W-1:0]  alt_c, vel_c, fuel_c;
  logic          carry_a, borrow_v, carry_v, borrow_f;

  logic [4:0]    alt_s, vsub_s, vadd_s, fuel_s;
  logic [3:0]    te;

  // Four single-digit slices: altitude add, velocity subtract/add, fuel subtract.
  always_comb begin
    alt_s  = bcd_add(a_sh[3:0], v_sh[3:0], carry_a);
    vsub_s = bcd_sub(v_sh[3:0], g_sh[3:0], borrow_v);
    vadd_s = bcd_add(vsub_s[3:0], te_sh[3:0], carry_v);
    fuel_s = bcd_sub(f_sh[3:0], te_sh[3:0], borrow_f);
  end

  assign te = (fuel_r == '0) ? 4'd0 : thrust_r;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      alt_r       <= ALTITUDE;
      vel_r       <= VELOCITY;
      fuel_r      <= FUEL;
      thrust_r    <= THRUST;
      busy_r      <= 1'b0;
      step_done_r <= 1'b0;
      overrun_r   <= 1'b0;
      land_r      <= 1'b0;
      crash_r     <= 1'b0;
      a_sh        <= '0;
      v_sh        <= '0;
      f_sh        <= '0;
      g_sh        <= '0;
      te_sh       <= '0;
      v_op        <= '0;
      alt_c       <= '0;
      vel_c       <= '0;
      fuel_c      <= '0;
      carry_a     <= 1'b0;
      borrow_v    <= 1'b0;
      carry_v     <= 1'b0;
      borrow_f    <= 1'b0;
    end else begin
      step_done_r <= 1'b0;
      overrun_r   <= 1'b0;

      if (bus.thrust_wr && (bus.thrust_in <= 4'd9)) thrust_r <= bus.thrust_in;

      case (state)
        IDLE: begin
          if (bus.tick) begin
            a_sh     <= alt_r;
            v_sh     <= vel_r;
            v_op     <= vel_r;
            f_sh     <= fuel_r;
            g_sh     <= GRAVITY;
            te_sh    <= {{(W-4){1'b0}}, te};
            carry_a  <= 1'b0;
            borrow_v <= 1'b0;
            carry_v  <= 1'b0;
            borrow_f <= 1'b0;
            cnt      <= '0;
            busy_r   <= 1'b1;
            state    <= CALC;
          end
        end

        CALC: begin
          overrun_r <= bus.tick;
          alt_c     <= {alt_s[3:0],  alt_c[W-1:4]};
          vel_c     <= {vadd_s[3:0], vel_c[W-1:4]};
          fuel_c    <= {fuel_s[3:0], fuel_c[W-1:4]};
          carry_a   <= alt_s[4];
          borrow_v  <= vsub_s[4];
          carry_v   <= vadd_s[4];
          borrow_f  <= fuel_s[4];
          a_sh      <= a_sh  >> 4;
          v_sh      <= v_sh  >> 4;
          f_sh      <= f_sh  >> 4;
          g_sh      <= g_sh  >> 4;
          te_sh     <= te_sh >> 4;
          if (cnt == CW'(DIGITS - 1)) state <= CHECK;
          else                        cnt   <= cnt + 1'b1;
        end

        CHECK: begin
          overrun_r   <= bus.tick;
          busy_r      <= 1'b0;
          step_done_r <= 1'b1;
          cnt         <= '0;
          fuel_r      <= non_pos(fuel_c) ? '0 : fuel_c;
          if (non_pos(alt_c)) begin
            alt_r <= '0;
            vel_r <= '0;
            // Touchdown is survivable when not descending faster than SAFE_VEL.
            if (!is_neg(v_op) || (v_op >= SAFE_VEL)) begin
              land_r <= 1'b1;
              state  <= LANDED;
            end else begin
              crash_r <= 1'b1;
              state   <= CRASHED;
            end
          end else begin
            alt_r <= alt_c;
            vel_r <= vel_c;
            state <= IDLE;
          end
        end

        default: ;  // LANDED and CRASHED hold until reset
      endcase
    end
  end

  assign bus.alt       = alt_r;
  assign bus.vel       = vel_r;
  assign bus.fuel      = fuel_r;
  assign bus.thrust    = thrust_r;
  assign bus.busy      = busy_r;
  assign bus.step_done = step_done_r;
  assign bus.overrun   = overrun_r;
  assign bus.land      = land_r;
  assign bus.crash     = crash_r;
endmodule

// File: tb/tb_ll_step_engine.sv
// Directed bench for ll_step_engine: six 4-digit configurations plus one 6-digit
// instance, all sharing clk/rst, with hand-computed expected BCD values.
module tb_ll_step_engine;
  localparam int N = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_v  [N];
  logic        wr_v    [N];
  logic [3:0]  tin_v   [N];
  logic [23:0] alt_v   [N];
  logic [23:0] vel_v   [N];
  logic [23:0] fuel_v  [N];
  logic [3:0]  thr_v   [N];
  logic        busy_v  [N];
  logic        done_v  [N];
  logic        ovr_v   [N];
  logic        land_v  [N];
  logic        crash_v [N];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  // 0 nominal, 1 soft landing, 2 crash, 3 low fuel, 4 SAFE_VEL edge land, 5 just-too-fast crash
  localparam logic [15:0] P_ALT  [6] = '{16'h4500, 16'h0020, 16'h0010, 16'h4500, 16'h0030, 16'h0031};
  localparam logic [15:0] P_VEL  [6] = '{16'h0000, 16'h9980, 16'h9950, 16'h0000, 16'h9970, 16'h9969};
  localparam logic [15:0] P_FUEL [6] = '{16'h0800, 16'h0800, 16'h0800, 16'h0003, 16'h0800, 16'h0800};
  localparam logic [3:0]  P_THR  [6] = '{4'h5, 4'h0, 4'h0, 4'h5, 4'h0, 4'h0};

  for (genvar g = 0; g < 6; g++) begin : g4
    ll_step_engine_if #(.DIGITS(4)) bus ();
    assign bus.tick      = tick_v[g];
    assign bus.thrust_wr = wr_v[g];
    assign bus.thrust_in = tin_v[g];
    ll_step_engine #(
      .DIGITS(4), .ALTITUDE(P_ALT[g]), .VELOCITY(P_VEL[g]), .FUEL(P_FUEL[g]),
      .THRUST(P_THR[g]), .GRAVITY(16'h0005), .SAFE_VEL(16'h9970)
    ) dut (.clk(clk), .rst(rst), .bus(bus));
    assign alt_v[g]   = {8'h00, bus.alt};
    assign vel_v[g]   = {8'h00, bus.vel};
    assign fuel_v[g]  = {8'h00, bus.fuel};
    assign thr_v[g]   = bus.thrust;
    assign busy_v[g]  = bus.busy;
    assign done_v[g]  = bus.step_done;
    assign ovr_v[g]   = bus.overrun;
    assign land_v[g]  = bus.land;
    assign crash_v[g] = bus.crash;
  end

  ll_step_engine_if #(.DIGITS(6)) bus6 ();
  assign bus6.tick      = tick_v[6];
  assign bus6.thrust_wr = wr_v[6];
  assign bus6.thrust_in = tin_v[6];
  ll_step_engine #(
    .DIGITS(6), .ALTITUDE(24'h004500), .VELOCITY(24'h000000), .FUEL(24'h000800),
    .THRUST(4'h5), .GRAVITY(24'h000005), .SAFE_VEL(24'h999970)
  ) dut6 (.clk(clk), .rst(rst), .bus(bus6));
  assign alt_v[6]   = bus6.alt;
  assign vel_v[6]   = bus6.vel;
  assign fuel_v[6]  = bus6.fuel;
  assign thr_v[6]   = bus6.thrust;
  assign busy_v[6]  = bus6.busy;
  assign done_v[6]  = bus6.step_done;
  assign ovr_v[6]   = bus6.overrun;
  assign land_v[6]  = bus6.land;
  assign crash_v[6] = bus6.crash;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Pulses tick (optionally with a thrust write) and returns the step_done latency
  // counted from the tick cycle, plus busy cycles seen; lat=0 means no step_done.
  task automatic do_step(input int k, input logic wr, input logic [3:0] tin,
                         output int lat, output int bcy);
    tick_v[k] = 1'b1;
    wr_v[k]   = wr;
    tin_v[k]  = tin;
    @(negedge clk);
    tick_v[k] = 1'b0;
    wr_v[k]   = 1'b0;
    lat = 0;
    bcy = 0;
    for (int c = 1; c <= 30; c++) begin
      if (busy_v[k]) bcy++;
      if (done_v[k]) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic write_thrust(input int k, input logic [3:0] v);
    wr_v[k]  = 1'b1;
    tin_v[k] = v;
    @(negedge clk);
    wr_v[k]  = 1'b0;
  endtask

  // Ticks a terminal instance and counts step_done/overrun pulses over ten cycles.
  task automatic quiet_tick(input int k, output int dones, output int ovrs);
    tick_v[k] = 1'b1;
    @(negedge clk);
    tick_v[k] = 1'b0;
    dones = 0;
    ovrs  = 0;
    repeat (10) begin
      if (done_v[k]) dones++;
      if (ovr_v[k])  ovrs++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, bcy, nd, no;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      tick_v[i] = 1'b0;
      wr_v[i]   = 1'b0;
      tin_v[i]  = 4'd0;
    end
    repeat (2) @(negedge clk);

    check("rst_alt",    alt_v[0],            24'h4500);
    check("rst_vel",    vel_v[0],            24'h0000);
    check("rst_fuel",   fuel_v[0],           24'h0800);
    check("rst_thrust", 24'(thr_v[0]),       24'h5);
    check("rst_busy",   24'(busy_v[0]),      24'h0);
    check("rst_done",   24'(done_v[0]),      24'h0);
    check("rst_ovr",    24'(ovr_v[0]),       24'h0);
    check("rst_land",   24'(land_v[0]),      24'h0);
    check("rst_crash",  24'(crash_v[0]),     24'h0);
    rst = 1'b1;
    @(negedge clk);

    // Nominal step, thrust 5 cancels gravity.
    do_step(0, 1'b0, 4'd0, lat, bcy);
    check("s1_latency", 24'(lat),       24'd6);
    check("s1_busy",    24'(bcy),       24'd5);
    check("s1_alt",     alt_v[0],       24'h4500);
    check("s1_vel",     vel_v[0],       24'h0000);
    check("s1_fuel",    fuel_v[0],      24'h0795);
    @(negedge clk);
    check("s1_done_pulse", 24'(done_v[0]), 24'h0);

    // Zero thrust: free fall, fuel untouched; out-of-range write ignored.
    do_reset();
    write_thrust(0, 4'd0);
    check("wr_zero", 24'(thr_v[0]), 24'h0);
    write_thrust(0, 4'hC);
    check("wr_ignored", 24'(thr_v[0]), 24'h0);
    do_step(0, 1'b0, 4'd0, lat, bcy);
    check("ff1_vel",  vel_v[0],  24'h9995);
    check("ff1_alt",  alt_v[0],  24'h4500);
    check("ff1_fuel", fuel_v[0], 24'h0800);
    do_step(0, 1'b0, 4'd0, lat, bcy);
    check("ff2_vel",  vel_v[0],  24'h9990);
    check("ff2_alt",  alt_v[0],  24'h4495);
    check("ff2_fuel", fuel_v[0], 24'h0800);

    // Tick with a simultaneous thrust write uses the old thrust (0) this step.
    do_step(0, 1'b1, 4'd3, lat, bcy);
    check("sim_vel",    vel_v[0],      24'h9985);
    check("sim_alt",    alt_v[0],      24'h4485);
    check("sim_fuel",   fuel_v[0],     24'h0800);
    check("sim_thrust", 24'(thr_v[0]), 24'h3);
    do_step(0, 1'b0, 4'd0, lat, bcy);
    check("sim2_vel",  vel_v[0],  24'h9983);
    check("sim2_alt",  alt_v[0],  24'h4470);
    check("sim2_fuel", fuel_v[0], 24'h0797);

    // Overrun at T+3 plus a thrust write mid-CALC; the step itself is unaffected.
    do_reset();
    tick_v[0] = 1'b1;
    @(negedge clk);
    tick_v[0] = 1'b0;
    wr_v[0]   = 1'b1;
    tin_v[0]  = 4'd7;
    @(negedge clk);
    wr_v[0]   = 1'b0;
    @(negedge clk);
    tick_v[0] = 1'b1;
    @(negedge clk);
    tick_v[0] = 1'b0;
    check("ovr_pulse",  24'(ovr_v[0]),  24'h1);
    check("ovr_thrust", 24'(thr_v[0]),  24'h7);
    @(negedge clk);
    check("ovr_clear",  24'(ovr_v[0]),  24'h0);
    check("ovr_busy",   24'(busy_v[0]), 24'h1);
    @(negedge clk);
    check("ovr_done",   24'(done_v[0]), 24'h1);
    check("ovr_alt",    alt_v[0],       24'h4500);
    check("ovr_vel",    vel_v[0],       24'h0000);
    check("ovr_fuel",   fuel_v[0],      24'h0795);
    do_step(0, 1'b0, 4'd0, lat, bcy);
    check("t7_vel",  vel_v[0],  24'h0002);
    check("t7_fuel", fuel_v[0], 24'h0788);
    check("t7_alt",  alt_v[0],  24'h4500);

    // Reset asserted mid-CALC.
    tick_v[0] = 1'b1;
    @(negedge clk);
    tick_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mr_alt",    alt_v[0],       24'h4500);
    check("mr_vel",    vel_v[0],       24'h0000);
    check("mr_fuel",   fuel_v[0],      24'h0800);
    check("mr_thrust", 24'(thr_v[0]),  24'h5);
    check("mr_busy",   24'(busy_v[0]), 24'h0);
    @(negedge clk);
    rst = 1'b1;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_v[0]) nd++;
    end
    check("mr_no_done", 24'(nd), 24'd0);

    // Soft landing, then terminal.
    do_step(1, 1'b0, 4'd0, lat, bcy);
    check("land_lat",   24'(lat),        24'd6);
    check("land_alt",   alt_v[1],        24'h0000);
    check("land_vel",   vel_v[1],        24'h0000);
    check("land_flag",  24'(land_v[1]),  24'h1);
    check("land_crash", 24'(crash_v[1]), 24'h0);
    check("land_fuel",  fuel_v[1],       24'h0800);
    quiet_tick(1, nd, no);
    check("land_no_done", 24'(nd), 24'd0);
    check("land_no_ovr",  24'(no), 24'd0);
    check("land_sticky",  24'(land_v[1]), 24'h1);

    // Crash.
    do_step(2, 1'b0, 4'd0, lat, bcy);
    check("crash_flag", 24'(crash_v[2]), 24'h1);
    check("crash_land", 24'(land_v[2]),  24'h0);
    check("crash_alt",  alt_v[2],        24'h0000);
    check("crash_vel",  vel_v[2],        24'h0000);
    quiet_tick(2, nd, no);
    check("crash_no_done", 24'(nd), 24'd0);
    check("crash_sticky",  24'(crash_v[2]), 24'h1);

    // Touchdown exactly at SAFE_VEL lands; one count faster crashes.
    do_step(4, 1'b0, 4'd0, lat, bcy);
    check("edge_land",  24'(land_v[4]),  24'h1);
    check("edge_lnd_c", 24'(crash_v[4]), 24'h0);
    do_step(5, 1'b0, 4'd0, lat, bcy);
    check("edge_crash", 24'(crash_v[5]), 24'h1);
    check("edge_crs_l", 24'(land_v[5]),  24'h0);

    // Fuel runs out: clamp to zero, then thrust no longer applied.
    do_step(3, 1'b0, 4'd0, lat, bcy);
    check("lf1_fuel", fuel_v[3], 24'h0000);
    check("lf1_vel",  vel_v[3],  24'h0000);
    do_step(3, 1'b0, 4'd0, lat, bcy);
    check("lf2_vel",  vel_v[3],  24'h9995);
    check("lf2_fuel", fuel_v[3], 24'h0000);
    check("lf2_alt",  alt_v[3],  24'h4500);

    // Six-digit build.
    do_step(6, 1'b0, 4'd0, lat, bcy);
    check("d6_latency", 24'(lat),  24'd8);
    check("d6_busy",    24'(bcy),  24'd7);
    check("d6_alt",     alt_v[6],  24'h004500);
    check("d6_vel",     vel_v[6],  24'h000000);
    check("d6_fuel",    fuel_v[6], 24'h000795);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
